// File: rtl/uart_baud_ctrl_if.sv
// Avalon-MM register port of the UART baud-rate controller.
// master drives address, strobes and write data; slave returns readdata.
interface uart_baud_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/uart_baud_ctrl.sv
// UART baud/oversample tick generator with Avalon-MM divisor/control registers.
// Latency: readdata one cycle after read; ticks decoded from the running counters.
// Backpressure: none, no waitrequest. Optional TICKCNT via UART_BAUD_TICKCNT_EN.
module uart_baud_ctrl #(
    parameter int unsigned OS_RATIO  = 16,
    parameter logic [31:0] RESET_DIV = 32'd27
) (
    input  logic             clk_i,
    input  logic             reset_n,
    uart_baud_ctrl_if.slave  bus,
    output logic             os_tick_o,
    output logic             baud_tick_o,
    output logic             running_o
);
    localparam int unsigned     PW         = $clog2(OS_RATIO);
    localparam logic [PW-1:0]   PHASE_LAST = PW'(OS_RATIO - 1);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t        state_q, state_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   active_q, active_d;
    logic          enable_q, enable_d;
    logic [31:0]   os_cnt_q, os_cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [31:0]   readdata_q, readdata_d;
    logic [31:0]   tickcnt_rd;

    logic [31:0]   eff_div;
    logic          div_wr, ctrl_wr, commit, stop;
    logic          os_tick, baud_tick;

    always_comb begin
        eff_div   = (active_q < 32'd2) ? 32'd2 : active_q;
        div_wr    = bus.write && (bus.address == 2'd0);
        ctrl_wr   = bus.write && (bus.address == 2'd1);
        enable_d  = ctrl_wr ? bus.writedata[0] : enable_q;
        commit    = ctrl_wr && bus.writedata[1];
        stop      = (state_q != IDLE) && !enable_d;
        // A disabling write suppresses the tick of its own cycle as well.
        os_tick   = (state_q != IDLE) && !stop && (os_cnt_q == eff_div - 32'd1);
        baud_tick = os_tick && (phase_q == PHASE_LAST);

        state_d   = state_q;
        active_d  = active_q;
        shadow_d  = div_wr ? bus.writedata : shadow_q;
        os_cnt_d  = os_cnt_q;
        phase_d   = phase_q;

        case (state_q)
            IDLE: begin
                os_cnt_d = '0;
                phase_d  = '0;
                if (commit)   active_d = shadow_q;
                if (enable_d) state_d  = RUN;
            end
            RUN, PEND: begin
                if (stop) begin
                    state_d  = IDLE;
                    os_cnt_d = '0;
                    phase_d  = '0;
                end else begin
                    if (os_tick) begin
                        os_cnt_d = '0;
                        phase_d  = baud_tick ? '0 : phase_q + 1'b1;
                    end else begin
                        os_cnt_d = os_cnt_q + 32'd1;
                    end
                    if (state_q == RUN && commit) state_d = PEND;
                    // Divisor swap lands exactly on a baud boundary, counters already wrap to 0.
                    if (state_q == PEND && baud_tick) begin
                        active_d = shadow_q;
                        state_d  = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        readdata_d = readdata_q;
        if (bus.read) begin
            case (bus.address)
                2'd0:    readdata_d = shadow_q;
                2'd1:    readdata_d = {31'b0, enable_q};
                2'd2:    readdata_d = {30'b0, state_q != IDLE, state_q == PEND};
                default: readdata_d = tickcnt_rd;
            endcase
        end
    end

`ifdef UART_BAUD_TICKCNT_EN
    logic [31:0] tickcnt_q, tickcnt_d;

    always_comb begin
        tickcnt_d = tickcnt_q;
        if (enable_q && !enable_d) tickcnt_d = '0;
        else if (baud_tick)        tickcnt_d = tickcnt_q + 32'd1;
        tickcnt_rd = tickcnt_q;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) tickcnt_q <= '0;
        else          tickcnt_q <= tickcnt_d;
    end
`else
    assign tickcnt_rd = '0;
`endif

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shadow_q   <= RESET_DIV;
            active_q   <= RESET_DIV;
            enable_q   <= 1'b0;
            os_cnt_q   <= '0;
            phase_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            enable_q   <= enable_d;
            os_cnt_q   <= os_cnt_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign os_tick_o    = os_tick;
    assign baud_tick_o  = baud_tick;
    assign running_o    = (state_q != IDLE);
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: a cycle-level arithmetic reference model
// queues expected outputs; an independent monitor pops and compares them.
module tb_uart_baud_ctrl;
    localparam int          OS   = 16;
    localparam logic [31:0] RDIV = 32'd27;

    logic clk_i   = 1'b0;
    logic reset_n = 1'b0;
    logic os_tick_o, baud_tick_o, running_o;

    uart_baud_ctrl_if bus();

    uart_baud_ctrl #(.OS_RATIO(OS), .RESET_DIV(RDIV)) dut (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .bus         (bus),
        .os_tick_o   (os_tick_o),
        .baud_tick_o (baud_tick_o),
        .running_o   (running_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        os;
        logic        baud;
        logic        run;
        logic [31:0] rd;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    // Reference model: mode 0 idle, 1 run, 2 pending; m_seg counts cycles since the
    // current run segment began, so ticks fall where (m_seg+1) is a multiple of the period.
    int          m_mode;
    bit          m_en;
    logic [31:0] m_shadow, m_active, m_tick, m_rd;
    longint      m_seg;

    task automatic model_reset();
        m_mode = 0; m_en = 1'b0; m_shadow = RDIV; m_active = RDIV;
        m_tick = '0; m_rd = '0; m_seg = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    endtask

    task automatic cycle(input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] wd);
        longint effl, pos;
        bit     run, new_en, stop, commit, os, bd;
        exp_t   e;
        @(negedge clk_i);
        bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;

        effl   = (m_active < 32'd2) ? 64'd2 : longint'(m_active);
        run    = (m_mode != 0);
        new_en = (wr && a == 2'd1) ? wd[0] : m_en;
        commit = wr && a == 2'd1 && wd[1];
        stop   = run && !new_en;
        pos    = m_seg + 1;
        os     = run && !stop && (pos % effl == 0);
        bd     = os && (pos % (effl * OS) == 0);
        e.os = os; e.baud = bd; e.run = run; e.rd = m_rd;
        expq.push_back(e);

        if (rd) begin
            case (a)
                2'd0: m_rd = m_shadow;
                2'd1: m_rd = {31'b0, m_en};
                2'd2: m_rd = {30'b0, run, m_mode == 2};
`ifdef UART_BAUD_TICKCNT_EN
                default: m_rd = m_tick;
`else
                default: m_rd = '0;
`endif
            endcase
        end
        if (m_en && !new_en) m_tick = '0;
        else if (bd)         m_tick = m_tick + 32'd1;

        case (m_mode)
            0: begin
                if (commit) m_active = m_shadow;
                if (new_en) begin m_mode = 1; m_seg = 0; end
            end
            1: begin
                if (stop) begin m_mode = 0; m_seg = 0; end
                else begin
                    m_seg++;
                    if (commit) m_mode = 2;
                end
            end
            default: begin
                if (stop) begin m_mode = 0; m_seg = 0; end
                else if (bd) begin m_active = m_shadow; m_mode = 1; m_seg = 0; end
                else m_seg++;
            end
        endcase
        if (wr && a == 2'd0) m_shadow = wd;
        m_en = new_en;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 2'd0, 32'd0);
    endtask
    task automatic rdreg(input logic [1:0] a);
        cycle(1'b1, 1'b0, a, 32'd0);
    endtask
    task automatic wrreg(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    always begin
        exp_t e;
        @(negedge clk_i);
        #2;
        if (mon_en && expq.size() > 0) begin
            e = expq.pop_front();
            check("os_tick",   {31'b0, os_tick_o},   {31'b0, e.os});
            check("baud_tick", {31'b0, baud_tick_o}, {31'b0, e.baud});
            check("running",   {31'b0, running_o},   {31'b0, e.run});
            check("readdata",  bus.readdata,         e.rd);
        end
    end

    initial begin
        bus.read = 1'b0; bus.write = 1'b0; bus.address = 2'd0; bus.writedata = '0;
        model_reset();
        #1;
        check("reset_os_tick",   {31'b0, os_tick_o},   32'd0);
        check("reset_baud_tick", {31'b0, baud_tick_o}, 32'd0);
        check("reset_running",   {31'b0, running_o},   32'd0);
        check("reset_readdata",  bus.readdata,         32'd0);
        repeat (3) @(negedge clk_i);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        idle(4);
        for (int a = 0; a < 4; a++) rdreg(2'(a));
        idle(2);

        // DIV=4, commit, enable
        wrreg(2'd0, 32'd4);
        wrreg(2'd1, 32'd2);
        wrreg(2'd1, 32'd1);
        idle(140);
        rdreg(2'd2);
        idle(2);

        // DIV=0 behaves as 2; ten baud periods for TICKCNT
        wrreg(2'd1, 32'd0);
        wrreg(2'd0, 32'd0);
        wrreg(2'd1, 32'd3);
        idle(10 * 2 * OS);
        rdreg(2'd3);
        idle(2);

        // Divisor change 4 -> 8 while running
        wrreg(2'd1, 32'd0);
        wrreg(2'd0, 32'd4);
        wrreg(2'd1, 32'd3);
        idle(30);
        wrreg(2'd0, 32'd8);
        wrreg(2'd1, 32'd3);
        rdreg(2'd2);
        wrreg(2'd1, 32'd3);
        idle(10);
        rdreg(2'd2);
        idle(60);
        rdreg(2'd2);
        idle(150);
        rdreg(2'd2);

        // Pending then disable; re-enable keeps old divisor
        wrreg(2'd1, 32'd0);
        wrreg(2'd0, 32'd4);
        wrreg(2'd1, 32'd3);
        idle(20);
        wrreg(2'd0, 32'd8);
        wrreg(2'd1, 32'd3);
        idle(5);
        wrreg(2'd1, 32'd0);
        rdreg(2'd2);
        idle(10);
        wrreg(2'd1, 32'd1);
        idle(80);
        rdreg(2'd0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70)      idle(1);
            else if (r < 85) rdreg(2'($urandom_range(0, 3)));
            else if (r < 92) cycle(1'($urandom_range(0, 1)), 1'b1, 2'd0, $urandom_range(0, 6));
            else             cycle(1'($urandom_range(0, 1)), 1'b1, 2'd1,
                                   {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
        end

        // Asynchronous reset mid-run
        wrreg(2'd1, 32'd0);
        wrreg(2'd0, 32'd5);
        wrreg(2'd1, 32'd3);
        rdreg(2'd0);
        idle(20);
        #3;
        mon_en = 1'b0;
        @(posedge clk_i);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_os_tick",   {31'b0, os_tick_o},   32'd0);
        check("async_baud_tick", {31'b0, baud_tick_o}, 32'd0);
        check("async_running",   {31'b0, running_o},   32'd0);
        check("async_readdata",  bus.readdata,         32'd0);
        model_reset();
        @(negedge clk_i);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(3);
        rdreg(2'd0);
        idle(3);
        #3;
        check("queue_drained", expq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
